// File: rtl/conv_pkg.sv
// Shared definitions for the CONV datapath stages: geometry, data width,
// memory-select codes and the pooling stage FSM encoding.
package conv_pkg;

  // Image geometry and word format (signed 4.16 fixed point).
  localparam int IMG_W = 64;
  localparam int DW    = 20;
  localparam int AW    = 12;

  // Memory select codes on the shared crd/cwr/csel bus.
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;
  localparam logic [2:0] CSEL_NONE = 3'b000;

  // Pooling stage FSM: four reads of a 2x2 window, then one write.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } state_t;

  // True for the four read states of a window.
  function automatic logic is_read_state(input state_t s);
    return (s == RD0) || (s == RD1) || (s == RD2) || (s == RD3);
  endfunction

endpackage

// File: rtl/maxpool_2x2_stage_pool_cmp.sv
// pool_cmp: combinational signed maximum of two DW-bit words.
// Optional feature macro: MAXPOOL_RELU_EN clamps a negative maximum to zero.
// Clamping at every compare step gives the same final value as clamping once,
// so the running max in the top may reuse this block for every step.
module pool_cmp #(
  parameter int DW = conv_pkg::DW
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_max
);

  logic [DW-1:0] w_max;

  // Signed compare over the full width; on a tie both operands are equal.
  assign w_max = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;

`ifdef MAXPOOL_RELU_EN
  // Negative results are clamped to zero.
  assign o_max = w_max[DW-1] ? '0 : w_max;
`else
  // Signed maximum passed through unchanged.
  assign o_max = w_max;
`endif

endmodule

// File: rtl/maxpool_2x2_stage.sv
// maxpool_2x2_stage: 2x2 stride-2 max-pooling from layer-0 memory into
// layer-1 memory over the shared crd/cwr/csel bus, one pass per start pulse.
// Optional feature macro: MAXPOOL_RELU_EN (ReLU clamp inside pool_cmp).
// All bus outputs are registered from the next FSM state, so a strobe is
// visible in the same cycle the FSM occupies the matching state. cdata_wr is
// the one combinational output: the last read word arrives during WR.
module maxpool_2x2_stage #(
  parameter int         IMG_W   = conv_pkg::IMG_W,
  parameter int         DW      = conv_pkg::DW,
  parameter int         AW      = conv_pkg::AW,
  parameter logic [2:0] SRC_SEL = conv_pkg::CSEL_L0,
  parameter logic [2:0] DST_SEL = conv_pkg::CSEL_L1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  import conv_pkg::*;

  // Bits of a full-resolution coordinate, of a window coordinate, and of the
  // packed window index {row, col}.
  localparam int CW = $clog2(IMG_W);
  localparam int HW = CW - 1;
  localparam int WW = 2 * HW;
  localparam logic [WW-1:0] WIN_LAST = '1;

  state_t        r_state;
  state_t        w_state_next;
  logic [WW-1:0] r_win;
  logic [WW-1:0] w_win_next;
  logic [HW-1:0] w_row;
  logic [HW-1:0] w_col;
  logic          w_rd_next;
  logic          w_wr_next;
  logic          w_row_odd;
  logic          w_col_odd;
  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] r_m;
  logic [DW-1:0] w_max;

  logic          r_busy;
  logic          r_done;
  logic          r_crd;
  logic          r_cwr;
  logic [2:0]    r_csel;
  logic [AW-1:0] r_caddr_rd;
  logic [AW-1:0] r_caddr_wr;

  // FSM state register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: four reads and one write per window, then DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RD0;
      RD0:     w_state_next = RD1;
      RD1:     w_state_next = RD2;
      RD2:     w_state_next = RD3;
      RD3:     w_state_next = WR;
      WR:      w_state_next = (r_win == WIN_LAST) ? DONE : RD0;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The window index advances as each write retires and wraps to zero after
  // the last window, so it is already cleared when the FSM returns to IDLE.
  assign w_win_next = (r_state == WR) ? r_win + 1'b1 : r_win;

  // Window counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_win <= '0;
    end else begin
      r_win <= w_win_next;
    end
  end

  // Address generation for the state about to be entered. Doubling the window
  // row/col and setting the low bit selects the four pixels without adders.
  assign w_row     = w_win_next[WW-1:HW];
  assign w_col     = w_win_next[HW-1:0];
  assign w_rd_next = is_read_state(w_state_next);
  assign w_wr_next = (w_state_next == WR);
  assign w_row_odd = (w_state_next == RD2) || (w_state_next == RD3);
  assign w_col_odd = (w_state_next == RD1) || (w_state_next == RD3);
  assign w_rd_addr = {w_row, w_row_odd, w_col, w_col_odd};
  assign w_wr_addr = AW'(w_win_next);

  // Registered bus outputs; idle addresses and select are held at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_cwr      <= 1'b0;
      r_csel     <= CSEL_NONE;
      r_caddr_rd <= '0;
      r_caddr_wr <= '0;
    end else begin
      r_busy     <= (w_state_next != IDLE) && (w_state_next != DONE);
      r_done     <= (w_state_next == DONE);
      r_crd      <= w_rd_next;
      r_cwr      <= w_wr_next;
      r_csel     <= w_rd_next ? SRC_SEL : (w_wr_next ? DST_SEL : CSEL_NONE);
      r_caddr_rd <= w_rd_next ? w_rd_addr : '0;
      r_caddr_wr <= w_wr_next ? w_wr_addr : '0;
    end
  end

  // Signed max of the running max and the word currently on the read bus.
  pool_cmp #(
    .DW (DW)
  ) u_pool_cmp (
    .i_a   (r_m),
    .i_b   (cdata_rd),
    .o_max (w_max)
  );

  // Running max: read data lags its request by one cycle, so RD1 captures
  // the first pixel and RD2/RD3 fold in the second and third.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m <= '0;
    end else begin
      case (r_state)
        RD1:      r_m <= cdata_rd;
        RD2, RD3: r_m <= w_max;
        default:  r_m <= r_m;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign cwr      = r_cwr;
  assign csel     = r_csel;
  assign caddr_rd = r_caddr_rd;
  assign caddr_wr = r_caddr_wr;
  // The fourth pixel is on cdata_rd during WR and is folded in here.
  assign cdata_wr = r_cwr ? w_max : '0;

endmodule

// File: tb/tb_maxpool_2x2_stage.sv
// Bench for maxpool_2x2_stage: behavioural layer-0/layer-1 memories, a
// scoreboard of expected writes, and directed runs (ramp, ignored restart,
// back-to-back, mid-run reset, start in DONE, signed patterns).
module tb_maxpool_2x2_stage;

  localparam int N_RD  = 4096;
  localparam int N_WR  = 1024;
  localparam int T_DONE = 5121;
  localparam int BUDGET = 6000;

`ifdef MAXPOOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;

  logic [19:0] l0 [0:4095];
  logic [19:0] l1 [0:4095];
  logic [19:0] rdata = '0;

  typedef struct {
    logic [11:0] a;
    logic [19:0] d;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int prot_err = 0;
  int extra_wr = 0;

  maxpool_2x2_stage dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  assign cdata_rd = rdata;

  // Synchronous memories: read data appears the cycle after the request.
  always @(posedge clk) begin
    if (crd) rdata <= l0[caddr_rd];
    if (cwr) l1[caddr_wr] <= cdata_wr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed max of four words, optionally clamped at zero.
  function automatic logic [19:0] ref_pool(input logic [19:0] a, b, c, d);
    logic signed [19:0] m;
    m = a;
    if ($signed(b) > m) m = b;
    if ($signed(c) > m) m = c;
    if ($signed(d) > m) m = d;
    if (RELU && m < 0) m = '0;
    return m;
  endfunction

  task automatic push_expected();
    exp_t e;
    int b;
    for (int w = 0; w < N_WR; w++) begin
      b = (w / 32) * 128 + (w % 32) * 2;
      e.a = 12'(w);
      e.d = ref_pool(l0[b], l0[b+1], l0[b+64], l0[b+65]);
      sb.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_crd"}, 32'(crd), 0);
    check({tag, "_cwr"}, 32'(cwr), 0);
    check({tag, "_csel"}, 32'(csel), 0);
    check({tag, "_caddr_rd"}, 32'(caddr_rd), 0);
    check({tag, "_caddr_wr"}, 32'(caddr_wr), 0);
    check({tag, "_cdata_wr"}, 32'(cdata_wr), 0);
  endtask

  // Bus protocol watch and scoreboard drain, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (crd && cwr) prot_err++;
    if (crd && csel !== 3'b001) prot_err++;
    if (cwr && csel !== 3'b011) prot_err++;
    if (!crd && !cwr && csel !== 3'b000) prot_err++;
    if (crd) n_rd++;
    if (cwr) begin
      n_wr++;
      if (sb.size() == 0) begin
        extra_wr++;
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(caddr_wr), 32'(e.a));
        check("wr_data", 32'(cdata_wr), 32'(e.d));
      end
    end
  end

  // One full run. mode 0: return in the done cycle (for back-to-back);
  // mode 1: check done is a single pulse; mode 2: also pulse start in DONE.
  task automatic do_run(input string tag, input int restart_at, input int mode);
    int cyc;
    bit seen;
    n_rd = 0; n_wr = 0; prot_err = 0; extra_wr = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy_c1"}, 32'(busy), 1);
      if (cyc == restart_at) start = 1'b1;
      else if (cyc == restart_at + 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_done_cycle"}, 32'(cyc), T_DONE);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    check({tag, "_reads"}, 32'(n_rd), N_RD);
    check({tag, "_writes"}, 32'(n_wr), N_WR);
    check({tag, "_protocol"}, 32'(prot_err), 0);
    check({tag, "_extra_wr"}, 32'(extra_wr), 0);
    check({tag, "_sb_left"}, 32'(sb.size()), 0);
    $display("run %s: done at cycle %0d, %0d reads, %0d writes", tag, cyc, n_rd, n_wr);
    if (mode == 2) begin
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    if (mode != 0) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 0);
      repeat (4) @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy), 0);
      check({tag, "_idle_crd"}, 32'(crd), 0);
    end
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_l1_0"}, 32'(l1[0]), 65);
    check({tag, "_l1_33"}, 32'(l1[33]), 195);
    check({tag, "_l1_1023"}, 32'(l1[1023]), 4095);
  endtask

  task automatic clear_l1();
    for (int i = 0; i < 4096; i++) l1[i] = '0;
  endtask

  initial begin
    int snap_rd;
    int snap_wr;
    bit done_seen;

    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4096; i++) l0[i] = 20'(i);
    clear_l1();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Ramp, then a back-to-back second run with an ignored start at 300.
    push_expected();
    do_run("ramp", 0, 0);
    check_ramp("ramp");
    clear_l1();
    push_expected();
    do_run("b2b_restart", 300, 1);
    check_ramp("b2b_restart");

    // Reset for one cycle at cycle 2000 of a run.
    clear_l1();
    push_expected();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2000) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b1;
    snap_rd = n_rd;
    snap_wr = n_wr;
    done_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 0);
    check("abort_no_rd", 32'(n_rd), 32'(snap_rd));
    check("abort_no_wr", 32'(n_wr), 32'(snap_wr));
    $display("run abort: reset at cycle 2000, %0d writes before reset", snap_wr);
    sb.delete();

    // Fresh start after the abort; start pulsed during DONE is ignored.
    clear_l1();
    push_expected();
    do_run("fresh", 0, 2);
    check_ramp("fresh");

    // Signed patterns over random background data.
    for (int i = 0; i < 4096; i++) l0[i] = 20'($urandom());
    l0[0] = 20'h80000; l0[1] = 20'h00010; l0[64] = 20'hFFFFF; l0[65] = 20'h00001;
    l0[2] = 20'hFFFFF; l0[3] = 20'hFFFFF; l0[66] = 20'hFFFFF; l0[67] = 20'hFFFFF;
    l0[4] = 20'hFFFFD; l0[5] = 20'hFFFFF; l0[68] = 20'hFFFF9; l0[69] = 20'hFFFFE;
    l0[6] = 20'h00005; l0[7] = 20'h00005; l0[70] = 20'h00005; l0[71] = 20'h00005;
    l0[8] = 20'h80000; l0[9] = 20'h80000; l0[72] = 20'h80001; l0[73] = 20'h80000;
    clear_l1();
    push_expected();
    do_run("signed", 0, 1);
    check("signed_mix", 32'(l1[0]), 32'h00010);
    check("signed_all_neg1", 32'(l1[1]), RELU ? 32'h0 : 32'hFFFFF);
    check("signed_neg_set", 32'(l1[2]), RELU ? 32'h0 : 32'hFFFFF);
    check("signed_tie", 32'(l1[3]), 32'h00005);
    check("signed_most_neg", 32'(l1[4]), RELU ? 32'h0 : 32'h80001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
